instr_sequencer: RTL
====================

# instr_sequencer

Upstream instruction feeder for `mipscpu`. Holds a small loadable program store and presents each word on `instrWord` with a one-cycle `newInstr` strobe. It then waits a fixed number of cycles so the multi-cycle CPU can finish before the next word. It replaces hand-driven instruction stimulus, so the CPU can run a short program (load / add / sub / store) autonomously from a single `start` pulse.

## Interface
- `DEPTH`, 16: program store entries (power of two, ≥2).
- `AW`, 4: address width, log2(DEPTH).
- `GAP`, 5: wait cycles after each `newInstr` strobe before the next word is set up (≥1).
- `Clk` input 1: clock, rising edge.
- `Reset` input 1: synchronous, active-high.
- `load_en` input 1: write `load_data` to store at `load_addr`.
- `load_addr` input AW: store write address.
- `load_data` input 32: instruction word to store.
- `prog_len` input AW+1: number of words to issue, sampled on `start`.
- `start` input 1: begin issuing from address 0.
- `abort` input 1: stop after the current strobe and go to DONE.
- `instrWord` output 32: instruction to the CPU.
- `newInstr` output 1: one-cycle issue strobe to the CPU.
- `busy` output 1: high in SETUP / PULSE / WAIT.
- `done` output 1: high in DONE.
- `issued` output AW+1: count of strobes issued since the last `start`.

## Operation
- States:
  - IDLE: reset state. Accepts `start` and `load_en`.
  - SETUP: drive `instrWord` = mem[pc].
  - PULSE: `newInstr`=1, then `pc`++ and `issued`++.
  - WAIT: count GAP cycles.
  - DONE: `done`=1. Accepts `start` and `load_en`.
- Transitions:
  - IDLE/DONE + `start`: latch len = min(`prog_len`, DEPTH), clear `pc` and `issued`. Go to SETUP if len>0, else DONE.
  - SETUP → PULSE, unconditionally.
  - PULSE → WAIT, unconditionally.
  - WAIT, at terminal count: go to DONE if `issued`==len or `abort` was latched, else SETUP.
- `abort` is latched in any busy state and cleared on `start`. It never truncates a strobe or a wait already in progress. In IDLE or DONE it is ignored.
- `load_en` is honoured only in IDLE or DONE; writes while busy are dropped. If `load_en` and `start` arrive in the same cycle, the write lands and `start` is accepted. Word 0 is read in SETUP one cycle later, so a write to address 0 is seen by the issue.
- `start` while busy is ignored.
- `instrWord` holds its last value through WAIT, DONE and IDLE until the next SETUP.
- The store is not cleared by `Reset`; its contents are undefined until loaded.

## Timing
- Reset values: state IDLE, `instrWord`=0, `newInstr`=0, `busy`=0, `done`=0, `issued`=0, `pc`=0, abort latch 0.
- `start` sampled at edge t:
  - SETUP in cycle t+1; `instrWord` is valid from t+1.
  - `newInstr` is high only in cycle t+2.
  - WAIT occupies t+3 … t+2+GAP.
- Issue period is GAP+2 cycles. `instrWord` is stable for at least 1 cycle before and GAP cycles after each strobe.
- `done` rises in the cycle after the final WAIT terminal count: (GAP+2)·len+1 cycles after `start`. It stays high until `start` or `Reset`.
- `Reset` in any state returns to IDLE on the next edge. A strobe in that cycle is dropped (`newInstr`=0 after the edge).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package / header `seq_defs`:
  - state encoding constants S_IDLE, S_SETUP, S_PULSE, S_WAIT, S_DONE;
  - the instruction width (32);
  - the default GAP.
- Sub-module `instr_store`: DEPTH×32 array with one synchronous write port and one asynchronous read port.
- The top holds the FSM, `pc`, `issued`, the GAP counter and the abort latch.

## Test plan
- **Reset:** Reset 2 cycles → all outputs 0, state IDLE; a `start` with `prog_len`=0 → `done`=1 after 1 cycle and `newInstr` is never asserted.
- **Six-instruction program:** load 0x8C010000, 0x8C020001, 0x8C030002, 0x00222020, 0x00832822, 0xAC050003; `start` with `prog_len`=6 and GAP=5.
  - Strobes at t+2, t+9, …, t+37, each carrying the matching word.
  - `done` at t+43.
  - With `mipscpu` attached and mem[0..2]=7, 83, 21, mem[3] ends at 69.
- **Length clamp:** `prog_len`=20 with DEPTH=16 → exactly 16 strobes, `issued`=16.
- **Abort:** `abort` during the 2nd WAIT of a 6-word run → exactly 2 strobes, then DONE; a new `start` runs all 6 strobes.
- **Blocked inputs while busy:** `load_en` to address 3 while busy → word unchanged on rerun; `start` while busy → no restart, strobe spacing unchanged.
- **Reset mid-run:** `Reset` in the PULSE cycle of word 2 → `newInstr`=0 next cycle, IDLE, `issued`=0; store contents intact and reissued correctly on the next `start`.

Source files
------------

// File: rtl/seq_defs.sv
// Shared definitions for the instruction sequencer: FSM encoding, word width, default gap.
package seq_defs;

    localparam int INSTR_W     = 32;
    localparam int DEFAULT_GAP = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/instr_store.sv
// Program store: DEPTH x INSTR_W words, one synchronous write port, one asynchronous read port.
module instr_store
    import seq_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               Clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // NOTE: the array is deliberately left out of reset so it maps onto plain RAM;
    // its contents are only meaningful once software has loaded them.
    always_ff @(posedge Clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues words from the program store to the CPU, one newInstr strobe per word,
// with a fixed GAP-cycle wait after each strobe so the multi-cycle CPU can finish.
module instr_sequencer
    import seq_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int GAP   = DEFAULT_GAP
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               load_en,
    input  logic [AW-1:0]      load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [AW:0]        prog_len,
    input  logic               start,
    input  logic               abort,
    output logic [INSTR_W-1:0] instrWord,
    output logic               newInstr,
    output logic               busy,
    output logic               done,
    output logic [AW:0]        issued
);

    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t             state;
    logic [AW-1:0]      pc;
    logic [AW:0]        len_q;
    logic [CW-1:0]      gap_cnt;
    logic               abort_q;

    logic               idle_like;
    logic               store_we;
    logic [AW-1:0]      raddr;
    logic [INSTR_W-1:0] rdata;
    logic [AW:0]        len_clamped;
    logic [INSTR_W-1:0] first_word;

    assign idle_like   = (state == S_IDLE) || (state == S_DONE);
    assign store_we    = load_en && idle_like;
    assign raddr       = idle_like ? '0 : pc;
    assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    // A write to address 0 in the start cycle must reach the first issued word.
    assign first_word  = (store_we && load_addr == '0) ? load_data : rdata;

    instr_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
        .Clk   (Clk),
        .we    (store_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    // NOTE: every register here uses <= so all updates see the pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            instrWord <= '0;
            newInstr  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            issued    <= '0;
            pc        <= '0;
            len_q     <= '0;
            gap_cnt   <= '0;
            abort_q   <= 1'b0;
        end else begin
            newInstr <= 1'b0;
            if (busy && abort) abort_q <= 1'b1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_q   <= len_clamped;
                        pc      <= '0;
                        issued  <= '0;
                        abort_q <= 1'b0;
                        if (len_clamped != '0) begin
                            state     <= S_SETUP;
                            instrWord <= first_word;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    state    <= S_PULSE;
                    newInstr <= 1'b1;
                end
                S_PULSE: begin
                    state   <= S_WAIT;
                    pc      <= pc + 1'b1;
                    issued  <= issued + 1'b1;
                    gap_cnt <= CW'(GAP - 1);
                end
                S_WAIT: begin
                    if (gap_cnt == '0) begin
                        // An abort arriving on the terminal-count cycle still stops the run.
                        if (issued == len_q || abort_q || abort) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_SETUP;
                            instrWord <= rdata;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
